fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter PROG_LEN, default 22: program length in halfwords; fetch never reads at or beyond it.
REQ-002 Parameter RESET_PC, default 0: halfword address of the first instruction.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 issue_cnt  in  2  instructions consumed by decode this cycle (0, 1 or 2); a value of 3 is treated as 0.
REQ-006 stall  in  1  hold the PC; no instruction is consumed.
REQ-007 branch_valid  in  1  redirect request.
REQ-008 branch_target  in  15  halfword address of the redirect.
REQ-009 Rom_addr_in  out  14  ROM row address, equal to pc[14:1].
REQ-010 pc_1  out  1  odd-PC flag, equal to pc[0]; the ROM adds it to the even-bank row.
REQ-011 sel_mem_0  out  2  IR_0 source: 0 = even bank, 2 = odd bank; 1 is never driven.
REQ-012 sel_mem_1  out  1  IR_1 source: 0 = even bank, 1 = odd bank.
REQ-013 valid_0, valid_1  out  1 each  IR_0 / IR_1 hold consumable instructions this cycle.
REQ-014 pc_out  out  15  halfword address of IR_0.

Function
REQ-015 The internal pc register (15 bits, halfword address) drives all ROM controls combinationally; instructions are visible on IR_0/IR_1 in the same cycle (zero latency).
REQ-016 Even pc drives sel_mem_0=0 and sel_mem_1=1; odd pc drives sel_mem_0=2 and sel_mem_1=0.
REQ-017 The state machine has four states: BOOT, RUN, FLUSH and DONE.
REQ-018 BOOT is entered on reset and advances to RUN (or to DONE if RESET_PC>=PROG_LEN) on the first clock after rst deasserts; valid_0 and valid_1 are 0 in BOOT.
REQ-019 In RUN: valid_0 = (pc < PROG_LEN) and valid_1 = (pc+1 < PROG_LEN).
REQ-020 In RUN, the effective consume count is min(issue_cnt, number of valid slots).
REQ-021 In RUN, pc advances by the effective consume count per cycle.
REQ-022 In RUN, stall=1 forces the effective consume count to 0.
REQ-023 When the advanced pc is >= PROG_LEN, pc is set to PROG_LEN and the state goes to DONE.
REQ-024 branch_valid=1 has priority over stall and issue_cnt in any state except BOOT: the next pc is branch_target and the next state is FLUSH.
REQ-025 FLUSH lasts one cycle with both valids at 0 while the ROM settles on the target; it is then followed by RUN, or by DONE if branch_target >= PROG_LEN.
REQ-026 A branch in FLUSH restarts FLUSH with the new target.
REQ-027 DONE holds pc with both valids at 0 until a branch or a reset.
REQ-028 pc arithmetic is 15-bit unsigned; pc saturates at PROG_LEN and never wraps.

Reset
REQ-029 During rst: state=BOOT, pc=RESET_PC, Rom_addr_in=RESET_PC[14:1], pc_1=RESET_PC[0], valid_0=0, valid_1=0, pc_out=RESET_PC, and perf_issued=0 when compiled in.
REQ-030 Reset asserted mid-operation, including in FLUSH, immediately restores the reset values regardless of branch_valid.

Configuration
REQ-031 Macro FETCH_CTRL_PERF_EN.
REQ-032 With FETCH_CTRL_PERF_EN defined, a 16-bit output perf_issued counts effective consumed instructions, saturates at 0xFFFF, and clears on reset.
REQ-033 Without FETCH_CTRL_PERF_EN, the perf_issued port and its counter are absent and all other behaviour is identical.

Verification
REQ-034 Reset release, issue_cnt=2 every cycle, PROG_LEN=22 -> pc_out follows 0,0(BOOT),2,4,...,20, then DONE at 22 with valids=0; sel_mem_0=0 and sel_mem_1=1 throughout.
REQ-035 Odd start: branch_target=5, then issue_cnt=2 -> one FLUSH cycle with valids 0, then pc_out=5, Rom_addr_in=2, pc_1=1, sel_mem_0=2, sel_mem_1=0, next pc_out=7.
REQ-036 Tail: pc=21 with issue_cnt=2 -> valid_0=1 and valid_1=0, pc advances by only 1 to 22, then DONE.
REQ-037 Simultaneous branch_valid=1, stall=1, issue_cnt=2 at pc=8, target 3 -> next pc=3 in FLUSH, then RUN at 3.
REQ-038 Reset asserted in FLUSH toward target 14 -> outputs immediately return to pc_out=0, valids=0, state BOOT; with FETCH_CTRL_PERF_EN, perf_issued reads 0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: dual-slot halfword PC sequencing over a banked ROM.
// Optional perf_issued counter is compiled in with `define FETCH_CTRL_PERF_EN.
module fetch_ctrl #(
    parameter int PROG_LEN = 22,
    parameter int RESET_PC = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  issue_cnt,
    input  logic        stall,
    input  logic        branch_valid,
    input  logic [14:0] branch_target,
    output logic [13:0] Rom_addr_in,
    output logic        pc_1,
    output logic [1:0]  sel_mem_0,
    output logic        sel_mem_1,
    output logic        valid_0,
    output logic        valid_1,
    output logic [14:0] pc_out,
`ifdef FETCH_CTRL_PERF_EN
    output logic [15:0] perf_issued,
`endif
    output logic [1:0]  state_dbg
);

    // Handshake: decode reports in issue_cnt how many of the valid slots it took this
    // cycle; only slots flagged valid_0/valid_1 can be consumed, and stall consumes none.

    localparam logic [15:0] LEN       = 16'(PROG_LEN);
    localparam logic [14:0] RST_PC    = 15'(RESET_PC);
    localparam bit          BOOT_DONE = (RESET_PC >= PROG_LEN);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [14:0] pc_q, pc_d;
    logic [15:0] pc_ext, adv;
    logic [1:0]  slots, req, eff;

    always_comb begin
        pc_ext  = {1'b0, pc_q};
        valid_0 = (state_q == RUN) && (pc_ext < LEN);
        valid_1 = (state_q == RUN) && ((pc_ext + 16'd1) < LEN);
        slots   = {1'b0, valid_0} + {1'b0, valid_1};
        req     = (stall || issue_cnt == 2'd3) ? 2'd0 : issue_cnt;
        // A branch pre-empts consumption: nothing counts as issued that cycle.
        eff     = 2'd0;
        if (state_q == RUN && !branch_valid)
            eff = (req < slots) ? req : slots;
        adv     = pc_ext + {14'd0, eff};

        state_d = state_q;
        pc_d    = pc_q;
        if (state_q == BOOT) begin
            state_d = BOOT_DONE ? DONE : RUN;
        end else if (branch_valid) begin
            pc_d    = branch_target;
            state_d = FLUSH;
        end else begin
            case (state_q)
                RUN: begin
                    if (adv >= LEN) begin
                        pc_d    = LEN[14:0];
                        state_d = DONE;
                    end else begin
                        pc_d    = adv[14:0];
                    end
                end
                FLUSH:   state_d = (pc_ext >= LEN) ? DONE : RUN;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RST_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic [15:0] perf_q, perf_d;
    logic [16:0] perf_sum;

    always_comb begin
        perf_sum = {1'b0, perf_q} + {15'd0, eff};
        perf_d   = perf_sum[16] ? 16'hFFFF : perf_sum[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) perf_q <= 16'd0;
        else     perf_q <= perf_d;
    end

    assign perf_issued = perf_q;
`endif

    assign Rom_addr_in = pc_q[14:1];
    assign pc_1        = pc_q[0];
    assign sel_mem_0   = pc_q[0] ? 2'd2 : 2'd0;
    assign sel_mem_1   = ~pc_q[0];
    assign pc_out      = pc_q;
    assign state_dbg   = state_q;

endmodule
